mem_access_ctrl: RTL and testbench
==================================

// Module: mem_access_ctrl
// PURPOSE
//  Request sequencer directly upstream of the 8x8 memory cell array.
//  - Accepts one read/write request at a time over a valid/ready handshake.
//  - Decodes the address to a one-hot word select.
//  - Sequences setup/strobe/hold timing on the array's valid, rw and select lines.
//  - Captures read data and returns a response over a second valid/ready handshake.
// PARAMETERS
//  ADDR_W         3  address width; NWORDS = 1<<ADDR_W word selects
//  DATA_W         8  data width (matches array i*/o* bit count)
//  ACCESS_CYCLES  2  cycles mem_valid is held high per access; legal range 1..15
// PORTS
//  clk         in   1        clock, rising edge
//  rst         in   1        asynchronous, active-high reset
//  req_valid   in   1        request present
//  req_ready   out  1        request accepted when req_valid&&req_ready
//  req_rw      in   1        1 = read, 0 = write
//  req_addr    in   ADDR_W   word address
//  req_wdata   in   DATA_W   write data
//  resp_valid  out  1        response present
//  resp_ready  in   1        response consumed when resp_valid&&resp_ready
//  resp_rdata  out  DATA_W   read data; 0 for writes (see CONFIGURATION)
//  resp_err    out  1        write-verify mismatch (see CONFIGURATION)
//  mem_valid   out  1        array valid strobe
//  mem_rw      out  1        array rw, same encoding as req_rw
//  mem_sel     out  NWORDS   one-hot word select to array sel0..sel7
//  mem_wdata   out  DATA_W   array input data i0..i7
//  mem_rdata   in   DATA_W   array output data o0..o7
//  busy        out  1        high in any state other than IDLE
// BEHAVIOUR
//  Reset values:
//  - All outputs 0 except req_ready = 1; FSM state IDLE.
//  - Reset mid-operation aborts the transaction: mem_valid and mem_sel drop
//    asynchronously, no response is issued, and the request is lost.
//  FSM states: IDLE -> SETUP -> ACCESS -> HOLD -> RESP -> IDLE.
//  - IDLE: req_ready=1. On handshake, register rw/addr/wdata; next state SETUP.
//  - SETUP (1 cycle): mem_sel=onehot(addr), mem_rw, mem_wdata driven; mem_valid=0.
//  - ACCESS (ACCESS_CYCLES cycles): mem_valid=1; sel/rw/wdata stable.
//    A 4-bit down-counter is loaded at entry. For reads, mem_rdata is sampled
//    into resp_rdata on the last ACCESS cycle.
//  - HOLD (1 cycle): mem_valid=0; sel/rw/wdata still held.
//  - RESP: mem_sel=0; resp_valid=1 until resp_ready; then IDLE.
//    resp_rdata and resp_err are stable while resp_valid is high.
//  - Latency: accept at cycle T gives resp_valid at T+3+ACCESS_CYCLES
//    (T+5 at default). With resp_ready tied high, throughput is one
//    transaction per 4+ACCESS_CYCLES cycles.
//  Handshake and timing rules:
//  - req_ready is 0 in every state except IDLE; no request queueing.
//  - resp_ready high in the same cycle resp_valid rises completes in 1 cycle.
//  - mem_valid never rises in the same cycle that mem_sel or mem_rw changes.
//  - mem_sel is all-zero whenever the FSM is outside SETUP/ACCESS/HOLD.
//  - Request inputs are ignored while busy; changes are not observed.
//  - Addresses wrap naturally; every ADDR_W value maps to exactly one sel bit.
// CONFIGURATION
//  MEMCTRL_WR_VERIFY_EN defined:
//  - After a write's HOLD, the FSM performs a read-back of the same word:
//    SETUP(rw=1) -> ACCESS -> HOLD, then RESP.
//  - resp_rdata carries the read-back value; resp_err=(read-back != wdata).
//  - Write latency becomes T+6+2*ACCESS_CYCLES.
//  MEMCTRL_WR_VERIFY_EN undefined:
//  - Writes go straight to RESP after HOLD.
//  - resp_err is tied 0; resp_rdata=0 for writes.
// TESTING
//  1. Reset, then write addr=3 data=8'hA5 -> mem_sel=8'b0000_1000; mem_valid high
//     2 cycles; resp_valid at T+5; resp_rdata=0.
//  2. Array model returns 8'h5A; read addr=7 -> mem_sel=8'b1000_0000, mem_rw=1;
//     resp_rdata=8'h5A at T+5.
//  3. Hold resp_ready=0 for 4 cycles -> resp_valid/resp_rdata stable;
//     req_ready=0 throughout; a new req_valid is not accepted.
//  4. Assert rst during ACCESS -> mem_valid=0, mem_sel=0 same cycle;
//     no resp_valid follows; req_ready=1.
//  5. VERIFY_EN: write 8'hFF while the model forces bit0 stuck-at-0 ->
//     resp_rdata=8'hFE, resp_err=1 at T+10.
//  6. Back-to-back requests, resp_ready=1, all 8 addresses -> each sel bit
//     one-hot exactly once; 6-cycle spacing.

Source files
------------

// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: setup/strobe/hold request sequencer for the 8x8 memory cell array; define MEMCTRL_WR_VERIFY_EN for write read-back verify
module mem_access_ctrl #(
    parameter int ADDR_W        = 3,
    parameter int DATA_W        = 8,
    parameter int ACCESS_CYCLES = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   req_valid,
    output logic                   req_ready,
    input  logic                   req_rw,
    input  logic [ADDR_W-1:0]      req_addr,
    input  logic [DATA_W-1:0]      req_wdata,
    output logic                   resp_valid,
    input  logic                   resp_ready,
    output logic [DATA_W-1:0]      resp_rdata,
    output logic                   resp_err,
    output logic                   mem_valid,
    output logic                   mem_rw,
    output logic [(1<<ADDR_W)-1:0] mem_sel,
    output logic [DATA_W-1:0]      mem_wdata,
    input  logic [DATA_W-1:0]      mem_rdata,
    output logic                   busy
);
    localparam int NWORDS = 1 << ADDR_W;
`ifdef MEMCTRL_WR_VERIFY_EN
    localparam bit VERIFY = 1'b1;
`else
    localparam bit VERIFY = 1'b0;
`endif

    typedef enum logic [2:0] {IDLE, SETUP, ACCESS, HOLD, RESP} state_t;

    state_t              state, state_n;
    logic                rw_q, vphase, err_q, active, rd_now, last;
    logic [ADDR_W-1:0]   addr_q;
    logic [DATA_W-1:0]   wdata_q, rdata_q;
    logic [3:0]          cnt;

    // Array and handshake outputs decode straight from state so reset clears them immediately
    always_comb begin
        active     = (state == SETUP) || (state == ACCESS) || (state == HOLD);
        rd_now     = rw_q || vphase;
        last       = (state == ACCESS) && (cnt == 4'd1);
        req_ready  = state == IDLE;
        busy       = state != IDLE;
        resp_valid = state == RESP;
        mem_valid  = state == ACCESS;
        mem_rw     = active && rd_now;
        mem_sel    = active ? (NWORDS'(1) << addr_q) : '0;
        mem_wdata  = active ? wdata_q : '0;
        resp_rdata = rdata_q;
        resp_err   = err_q;
    end

    // Next state; the read-back SETUP spans two cycles to give the array an rw turnaround after the write
    always_comb begin
        state_n = state;
        case (state)
            IDLE:    state_n = req_valid ? SETUP : IDLE;
            SETUP:   state_n = (cnt == 4'd0) ? ACCESS : SETUP;
            ACCESS:  state_n = (cnt == 4'd1) ? HOLD : ACCESS;
            HOLD:    state_n = (VERIFY && !rw_q && !vphase) ? SETUP : RESP;
            RESP:    state_n = resp_ready ? IDLE : RESP;
            default: state_n = IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_n;
    end

    // Request capture, access counter and read-data sampling on the last strobe cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rw_q    <= 1'b0;
            vphase  <= 1'b0;
            err_q   <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            cnt     <= '0;
        end else begin
            if (state == IDLE && req_valid) begin
                rw_q    <= req_rw;
                addr_q  <= req_addr;
                wdata_q <= req_wdata;
                rdata_q <= '0;
                err_q   <= 1'b0;
                vphase  <= 1'b0;
                cnt     <= '0;
            end
            if (state == SETUP)
                cnt <= (cnt == 4'd0) ? 4'(ACCESS_CYCLES) : cnt - 4'd1;
            if (state == ACCESS)
                cnt <= cnt - 4'd1;
            if (last && rd_now) begin
                rdata_q <= mem_rdata;
                err_q   <= vphase && (mem_rdata != wdata_q);
            end
            if (state == HOLD && state_n == SETUP) begin
                vphase <= 1'b1;
                cnt    <= 4'd1;
            end
        end
    end
endmodule

// File: tb/tb_mem_access_ctrl.sv
// tb_mem_access_ctrl: scoreboard bench for mem_access_ctrl with a behavioural 8x8 array model
module tb_mem_access_ctrl;
    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       req_valid, req_ready, req_rw, resp_valid, resp_ready, resp_err;
    logic       mem_valid, mem_rw, busy;
    logic [2:0] req_addr;
    logic [7:0] req_wdata, resp_rdata, mem_sel, mem_wdata, mem_rdata;

    mem_access_ctrl dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_rw(req_rw),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_rdata(resp_rdata), .resp_err(resp_err),
        .mem_valid(mem_valid), .mem_rw(mem_rw), .mem_sel(mem_sel),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .busy(busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [7:0] mem [8];
    logic [7:0] stuck = 8'h00;
    logic       init_mem = 1'b1;
    logic [2:0] idx;

    always_comb begin
        idx = 3'd0;
        for (int i = 0; i < 8; i++)
            if (mem_sel[i]) idx = 3'(i);
    end

    assign mem_rdata = mem[idx] & ~stuck;

    always @(posedge clk) begin
        if (init_mem) begin
            for (int i = 0; i < 8; i++) mem[i] <= 8'h10 + 8'(i);
            mem[7] <= 8'h5A;
        end else if (mem_valid && !mem_rw)
            mem[idx] <= mem_wdata;
    end

    typedef struct {
        logic [7:0] rdata;
        logic       err;
        logic [7:0] sel;
        logic       rw;
        int         t;
        int         lat;
        int         vlen;
    } exp_t;

    exp_t       q[$];
    int         cmp = 0;
    int         bad = 0;
    logic [7:0] seen = 8'h00;

    task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
        cmp++;
        if (a !== e) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", n, a, e, cyc);
        end
    endtask

    initial begin
        logic       pv = 1'b0, prw = 1'b0, prv = 1'b0;
        logic [7:0] ps = 8'h00;
        int         vcnt = 0;
        forever begin
            @(negedge clk);
            if (rst)
                vcnt = 0;
            else begin
                if (mem_valid && !pv)
                    chk("sel_rw_stable_at_strobe", {mem_sel, mem_rw}, {ps, prw});
                if (mem_valid && q.size() > 0) begin
                    vcnt++;
                    seen |= mem_sel;
                    chk("mem_sel", mem_sel, q[0].sel);
                    chk("mem_rw", mem_rw, q[0].rw);
                end
                if (resp_valid && !prv) begin
                    if (q.size() == 0)
                        chk("resp_without_req", resp_valid, 1'b0);
                    else
                        chk("resp_latency", cyc - q[0].t, q[0].lat);
                end
                if (resp_valid && resp_ready && q.size() > 0) begin
                    chk("resp_rdata", resp_rdata, q[0].rdata);
                    chk("resp_err", resp_err, q[0].err);
                    chk("mem_valid_len", vcnt, q[0].vlen);
                    vcnt = 0;
                    void'(q.pop_front());
                end
            end
            pv  = mem_valid;
            ps  = mem_sel;
            prw = mem_rw;
            prv = resp_valid;
        end
    end

    task automatic issue(input logic rw, input logic [2:0] a, input logic [7:0] d,
                         input logic [7:0] er, input logic ee, input int lat,
                         input int vlen, input bit push, output int t);
        req_valid = 1'b1;
        req_rw    = rw;
        req_addr  = a;
        req_wdata = d;
        t = -1;
        for (int i = 0; i < 100 && t < 0; i++) begin
            @(negedge clk);
            if (req_ready) t = cyc;
        end
        if (t < 0)
            chk("req_accept_timeout", req_ready, 1'b1);
        else if (push)
            q.push_back('{er, ee, 8'(1) << a, rw, t, lat, vlen});
        @(posedge clk);
        #1;
        req_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (q.size() > 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (q.size() > 0) chk("drain_timeout", q.size(), 0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int         t, tp, n;
        logic       rv_seen;
        logic [7:0] rd_exp [8];
        rd_exp = '{8'h10, 8'h11, 8'h12, 8'hA5, 8'h14, 8'h15, 8'h16, 8'h5A};
        req_valid  = 1'b0;
        req_rw     = 1'b0;
        req_addr   = 3'd0;
        req_wdata  = 8'h00;
        resp_ready = 1'b1;
        #1 rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        init_mem = 1'b0;
        chk("rst_req_ready", req_ready, 1'b1);
        chk("rst_resp_valid", resp_valid, 1'b0);
        chk("rst_mem_valid", mem_valid, 1'b0);
        chk("rst_mem_sel", mem_sel, 8'h00);
        chk("rst_mem_rw", mem_rw, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_resp_rdata", resp_rdata, 8'h00);
        chk("rst_resp_err", resp_err, 1'b0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        issue(1'b0, 3'd3, 8'hA5, 8'h00, 1'b0, 5, 2, 1'b1, t);
        drain();
        chk("write_stored", mem[3], 8'hA5);

        issue(1'b1, 3'd7, 8'h00, 8'h5A, 1'b0, 5, 2, 1'b1, t);
        drain();

        resp_ready = 1'b0;
        issue(1'b1, 3'd0, 8'h00, 8'h10, 1'b0, 5, 2, 1'b1, t);
        n = 0;
        while (!resp_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("stall_resp_seen", resp_valid, 1'b1);
        @(posedge clk);
        #1;
        req_valid = 1'b1;
        req_rw    = 1'b0;
        req_addr  = 3'd5;
        req_wdata = 8'h33;
        repeat (4) begin
            @(negedge clk);
            chk("stall_resp_valid", resp_valid, 1'b1);
            chk("stall_resp_rdata", resp_rdata, 8'h10);
            chk("stall_req_ready", req_ready, 1'b0);
        end
        @(posedge clk);
        #1;
        req_valid  = 1'b0;
        resp_ready = 1'b1;
        drain();
        repeat (10) @(negedge clk);
        chk("stray_req_not_taken", busy, 1'b0);
        chk("stray_write_absent", mem[5], 8'h15);

        @(posedge clk);
        #1;
        issue(1'b1, 3'd2, 8'h00, 8'h00, 1'b0, 5, 2, 1'b0, t);
        @(posedge clk);
        #1;
        chk("pre_rst_in_access", mem_valid, 1'b1);
        rst = 1'b1;
        #1;
        chk("rst_abort_mem_valid", mem_valid, 1'b0);
        chk("rst_abort_mem_sel", mem_sel, 8'h00);
        chk("rst_abort_req_ready", req_ready, 1'b1);
        @(posedge clk);
        #1;
        rst = 1'b0;
        rv_seen = 1'b0;
        repeat (12) begin
            @(negedge clk);
            rv_seen |= resp_valid;
        end
        chk("no_resp_after_rst", rv_seen, 1'b0);
        chk("idle_after_rst", req_ready, 1'b1);
        @(posedge clk);
        #1;

`ifdef MEMCTRL_WR_VERIFY_EN
        stuck = 8'h01;
        issue(1'b0, 3'd1, 8'hFF, 8'hFE, 1'b1, 10, 4, 1'b1, t);
        drain();
        stuck = 8'h00;
`endif

        seen = 8'h00;
        tp = 0;
        for (int a = 0; a < 8; a++) begin
            issue(1'b1, 3'(a), 8'h00, rd_exp[a], 1'b0, 5, 2, 1'b1, t);
            if (a > 0) chk("b2b_spacing", t - tp, 6);
            tp = t;
        end
        drain();
        chk("sel_coverage", seen, 8'hFF);
        chk("final_queue_empty", q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, bad);
        $finish;
    end
endmodule
